// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, ALU selects,
// FSM states, decoded-control and registered-output bundles.
package cpu_pkg;

  localparam int CPU_OPCODE_W = 4;
  localparam int CPU_ALU_OP_W = 3;
  localparam int CPU_CNT_W    = 16;

  localparam logic [CPU_OPCODE_W-1:0] OP_NOP  = 4'h0;
  localparam logic [CPU_OPCODE_W-1:0] OP_ADD  = 4'h1;
  localparam logic [CPU_OPCODE_W-1:0] OP_SUB  = 4'h2;
  localparam logic [CPU_OPCODE_W-1:0] OP_AND  = 4'h3;
  localparam logic [CPU_OPCODE_W-1:0] OP_OR   = 4'h4;
  localparam logic [CPU_OPCODE_W-1:0] OP_XOR  = 4'h5;
  localparam logic [CPU_OPCODE_W-1:0] OP_ADDI = 4'h6;
  localparam logic [CPU_OPCODE_W-1:0] OP_ANDI = 4'h7;
  localparam logic [CPU_OPCODE_W-1:0] OP_LD   = 4'h8;
  localparam logic [CPU_OPCODE_W-1:0] OP_ST   = 4'h9;
  localparam logic [CPU_OPCODE_W-1:0] OP_HLT  = 4'hF;

  localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_ADD = 3'b000;
  localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_SUB = 3'b001;
  localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_AND = 3'b010;
  localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_OR  = 3'b011;
  localparam logic [CPU_ALU_OP_W-1:0] ALU_OP_XOR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALTED
  } state_t;

  typedef struct packed {
    logic [CPU_ALU_OP_W-1:0] alu_op;
    logic                    alu_src;
    logic                    imm_signed;
    logic                    is_mem;
    logic                    is_store;
    logic                    writes_reg;
    logic                    is_halt;
    logic                    illegal;
  } dec_t;

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic                    alu_src;
    logic                    imm_signed;
    logic [CPU_ALU_OP_W-1:0] alu_op;
    logic                    mem_to_reg;
    logic                    pc_write;
    logic                    busy;
    logic                    halted;
  } ctrl_t;

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode decode into the static control fields of an instruction.
module control_decoder
  import cpu_pkg::*;
(
  input  logic [CPU_OPCODE_W-1:0] i_opcode,
  output dec_t                    o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_opcode)
      OP_NOP: ;
      OP_ADD: begin o_dec.alu_op = ALU_OP_ADD; o_dec.writes_reg = 1'b1; end
      OP_SUB: begin o_dec.alu_op = ALU_OP_SUB; o_dec.writes_reg = 1'b1; end
      OP_AND: begin o_dec.alu_op = ALU_OP_AND; o_dec.writes_reg = 1'b1; end
      OP_OR:  begin o_dec.alu_op = ALU_OP_OR;  o_dec.writes_reg = 1'b1; end
      OP_XOR: begin o_dec.alu_op = ALU_OP_XOR; o_dec.writes_reg = 1'b1; end
      OP_ADDI: begin
        o_dec.alu_op     = ALU_OP_ADD;
        o_dec.alu_src    = 1'b1;
        o_dec.imm_signed = 1'b1;
        o_dec.writes_reg = 1'b1;
      end
      OP_ANDI: begin
        o_dec.alu_op     = ALU_OP_AND;
        o_dec.alu_src    = 1'b1;
        o_dec.writes_reg = 1'b1;
      end
      OP_LD: begin
        o_dec.alu_op     = ALU_OP_ADD;
        o_dec.alu_src    = 1'b1;
        o_dec.is_mem     = 1'b1;
        o_dec.writes_reg = 1'b1;
      end
      OP_ST: begin
        o_dec.alu_op   = ALU_OP_ADD;
        o_dec.alu_src  = 1'b1;
        o_dec.is_mem   = 1'b1;
        o_dec.is_store = 1'b1;
      end
      OP_HLT:  o_dec.is_halt = 1'b1;
      // A..E retire as NOP but are flagged
      default: o_dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with registered (Moore) strobes.
// Optional retired-instruction counter built when RETIRE_COUNT_EN is defined.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = CPU_OPCODE_W,
  parameter int ALU_OP_W = CPU_ALU_OP_W,
  parameter int CNT_W    = CPU_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          instruction,
  output logic                reg_write,
  output logic                mem_write,
  output logic                alu_src,
  output logic                imm_signed,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                pc_write,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired_count
);

  state_t              r_state, w_nxt_state;
  logic [OPCODE_W-1:0] r_ir;
  logic [OPCODE_W-1:0] w_ir_nxt;
  dec_t                w_dec;
  ctrl_t               r_ctrl, w_nxt_ctrl;
  logic                r_illegal;
  logic                w_unused_operand;

  // Operand nibble is consumed by the datapath, not by control.
  assign w_unused_operand = ^instruction[7-OPCODE_W:0];

  // Decode what IR will hold next so registered outputs line up with the state.
  assign w_ir_nxt = (r_state == ST_FETCH) ? instruction[7 -: OPCODE_W] : r_ir;

  control_decoder u_dec (
    .i_opcode (w_ir_nxt),
    .o_dec    (w_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_ir      <= w_ir_nxt;
      r_ctrl    <= w_nxt_ctrl;
      r_illegal <= r_illegal | ((w_nxt_state == ST_DECODE) & w_dec.illegal);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nxt_state = ST_FETCH;
      ST_FETCH:  w_nxt_state = ST_DECODE;
      ST_DECODE: w_nxt_state = w_dec.is_halt ? ST_HALTED : ST_EXEC;
      ST_EXEC:   w_nxt_state = w_dec.is_mem ? ST_MEM : ST_WB;
      ST_MEM:    w_nxt_state = ST_WB;
      ST_WB:     w_nxt_state = ST_FETCH;
      ST_HALTED: w_nxt_state = ST_HALTED;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_ctrl = '0;
    if (w_nxt_state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
      w_nxt_ctrl.alu_op     = w_dec.alu_op;
      w_nxt_ctrl.alu_src    = w_dec.alu_src;
      w_nxt_ctrl.imm_signed = w_dec.imm_signed;
    end
    w_nxt_ctrl.mem_write  = (w_nxt_state == ST_MEM) & w_dec.is_store;
    w_nxt_ctrl.mem_to_reg = (w_nxt_state inside {ST_MEM, ST_WB}) & w_dec.is_mem & ~w_dec.is_store;
    w_nxt_ctrl.reg_write  = (w_nxt_state == ST_WB) & w_dec.writes_reg;
    w_nxt_ctrl.pc_write   = (w_nxt_state == ST_WB);
    w_nxt_ctrl.busy       = ~(w_nxt_state inside {ST_IDLE, ST_HALTED});
    w_nxt_ctrl.halted     = (w_nxt_state == ST_HALTED);
  end

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               r_count <= '0;
    else if (r_ctrl.pc_write) r_count <= r_count + 1'b1;
  end

  assign retired_count = r_count;
`else
  assign retired_count = '0;
`endif

  assign reg_write  = r_ctrl.reg_write;
  assign mem_write  = r_ctrl.mem_write;
  assign alu_src    = r_ctrl.alu_src;
  assign imm_signed = r_ctrl.imm_signed;
  assign alu_op     = r_ctrl.alu_op;
  assign mem_to_reg = r_ctrl.mem_to_reg;
  assign pc_write   = r_ctrl.pc_write;
  assign busy       = r_ctrl.busy;
  assign halted     = r_ctrl.halted;
  assign illegal_op = r_illegal;

endmodule
